forth_mem_arbiter: RTL and testbench

FORTH_MEM_ARBITER -- requirements
Module: forth_mem_arbiter

---
 rtl/forth_bus_pkg.sv | 33 +++
 rtl/bus_watchdog.sv | 29 ++
 rtl/forth_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_forth_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forth_bus_pkg.sv
// Shared definitions for the Forth CPU-side bus blocks: transaction state
// encoding, grant encodings, default watchdog width and the round-robin pick.
package forth_bus_pkg;

  localparam int DEFAULT_TIMEOUT_BITS = 8;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_BUSY = 2'd1,
    BUS_RESP = 2'd2
  } bus_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // On a tie the master that did not own the previous transaction wins.
  function automatic logic [1:0] rr_pick(input logic m0_req,
                                         input logic m1_req,
                                         input logic last_m1);
    logic [1:0] pick;
    pick = GRANT_NONE;
    if (m0_req && m1_req) begin
      pick = last_m1 ? GRANT_M0 : GRANT_M1;
    end else if (m0_req) begin
      pick = GRANT_M0;
    end else if (m1_req) begin
      pick = GRANT_M1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Slave watchdog: counts enabled cycles and flags the last allowed one.
// expired is high during the (2^TIMEOUT_BITS-1)-th enabled cycle; TIMEOUT_BITS >= 2.
module bus_watchdog
  import forth_bus_pkg::*;
#(
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_BITS-1:0] LAST_COUNT = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  logic [TIMEOUT_BITS-1:0] count_q;

  assign expired = enable && (count_q == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/forth_mem_arbiter.sv
// Two-master, single-slave memory arbiter with round-robin tie break and a
// slave watchdog that completes a hung transaction with an error.
module forth_mem_arbiter
  import forth_bus_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic             clk,
  input  logic             nreset,

  input  logic             m0_valid,
  input  logic             m0_nwr,
  input  logic [WIDTH-1:0] m0_address,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_ready,
  output logic             m0_error,
  output logic [WIDTH-1:0] m0_rdata,

  input  logic             m1_valid,
  input  logic             m1_nwr,
  input  logic [WIDTH-1:0] m1_address,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_ready,
  output logic             m1_error,
  output logic [WIDTH-1:0] m1_rdata,

  output logic             s_valid,
  output logic             s_nwr,
  output logic [WIDTH-1:0] s_address,
  output logic [WIDTH-1:0] s_wdata,
  input  logic             s_ready,
  input  logic [WIDTH-1:0] s_rdata,

  output logic [1:0]       grant
);

  bus_state_e state_q, state_d;
  logic [1:0] grant_q;
  logic [1:0] pick;
  logic       last_m1_q;
  logic       timed_out_q;
  logic       wd_expired;
  logic       in_busy;

  assign in_busy = (state_q == BUS_BUSY);
  assign pick    = rr_pick(m0_valid, m1_valid, last_m1_q);

  bus_watchdog #(
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_watchdog (
    .clk     (clk),
    .nreset  (nreset),
    .clear   (!in_busy),
    .enable  (in_busy),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (m0_valid || m1_valid) state_d = BUS_BUSY;
      BUS_BUSY: if (s_ready || wd_expired) state_d = BUS_RESP;
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Slave request is latched at grant so it stays stable for the whole of BUSY
  // regardless of what the masters do; s_ready beats a simultaneous timeout.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      grant_q     <= GRANT_NONE;
      last_m1_q   <= 1'b1;
      timed_out_q <= 1'b0;
      s_valid     <= 1'b0;
      s_nwr       <= 1'b1;
      s_address   <= '0;
      s_wdata     <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      case (state_q)
        BUS_IDLE: begin
          if (pick != GRANT_NONE) begin
            grant_q     <= pick;
            last_m1_q   <= pick[1];
            timed_out_q <= 1'b0;
            s_valid     <= 1'b1;
            s_nwr       <= pick[1] ? m1_nwr     : m0_nwr;
            s_address   <= pick[1] ? m1_address : m0_address;
            s_wdata     <= pick[1] ? m1_wdata   : m0_wdata;
          end
        end
        BUS_BUSY: begin
          if (s_ready || wd_expired) begin
            s_valid     <= 1'b0;
            s_nwr       <= 1'b1;
            timed_out_q <= !s_ready;
            if (grant_q[0]) begin
              m0_rdata <= s_ready ? s_rdata : '1;
            end
            if (grant_q[1]) begin
              m1_rdata <= s_ready ? s_rdata : '1;
            end
          end
        end
        BUS_RESP: begin
          grant_q     <= GRANT_NONE;
          timed_out_q <= 1'b0;
        end
        default: begin
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign m0_ready = (state_q == BUS_RESP) && grant_q[0];
  assign m1_ready = (state_q == BUS_RESP) && grant_q[1];
  assign m0_error = m0_ready && timed_out_q;
  assign m1_error = m1_ready && timed_out_q;

endmodule

// File: tb/tb_forth_mem_arbiter.sv
// Directed scoreboard bench for forth_mem_arbiter: the bench plays both masters
// and the slave, queuing the expected transaction order as requests are raised.
module tb_forth_mem_arbiter;
  import forth_bus_pkg::*;

  localparam int WIDTH   = 16;
  localparam int TB_BITS = 3;
  localparam int LIMIT   = (1 << TB_BITS) - 1;

  logic             clk = 1'b0;
  logic             nreset;
  logic             m0_valid, m0_nwr, m0_ready, m0_error;
  logic [WIDTH-1:0] m0_address, m0_wdata, m0_rdata;
  logic             m1_valid, m1_nwr, m1_ready, m1_error;
  logic [WIDTH-1:0] m1_address, m1_wdata, m1_rdata;
  logic             s_valid, s_nwr, s_ready;
  logic [WIDTH-1:0] s_address, s_wdata, s_rdata;
  logic [1:0]       grant;

  typedef struct {
    logic [1:0]       grant;
    logic             nwr;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] slave_data;
    logic [WIDTH-1:0] rdata;
    logic             err;
  } txn_t;

  txn_t             exp_q[$];
  logic [WIDTH-1:0] last_rdata [2];
  int               passed = 0;
  int               failed = 0;
  int               total  = 0;

  always #5 clk = ~clk;

  forth_mem_arbiter #(
    .WIDTH        (WIDTH),
    .TIMEOUT_BITS (TB_BITS)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .m0_valid   (m0_valid),
    .m0_nwr     (m0_nwr),
    .m0_address (m0_address),
    .m0_wdata   (m0_wdata),
    .m0_ready   (m0_ready),
    .m0_error   (m0_error),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_nwr     (m1_nwr),
    .m1_address (m1_address),
    .m1_wdata   (m1_wdata),
    .m1_ready   (m1_ready),
    .m1_error   (m1_error),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_nwr      (s_nwr),
    .s_address  (s_address),
    .s_wdata    (s_wdata),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic nwr, input logic [WIDTH-1:0] addr,
                               input logic [WIDTH-1:0] wdata,
                               input logic [WIDTH-1:0] slave_data, input logic timeout);
    txn_t t;
    t.grant      = (m == 0) ? 2'b01 : 2'b10;
    t.nwr        = nwr;
    t.addr       = addr;
    t.wdata      = wdata;
    t.slave_data = slave_data;
    t.rdata      = timeout ? {WIDTH{1'b1}} : slave_data;
    t.err        = timeout;
    exp_q.push_back(t);
    if (m == 0) begin
      m0_valid = 1'b1; m0_nwr = nwr; m0_address = addr; m0_wdata = wdata;
    end else begin
      m1_valid = 1'b1; m1_nwr = nwr; m1_address = addr; m1_wdata = wdata;
    end
  endtask

  // Acts as the slave for one transaction; latency counts BUSY cycles after
  // s_valid is first seen before s_ready is raised.
  task automatic serveSlave(input int latency, input bit respond, output logic [1:0] served);
    txn_t t;
    bit   seen;
    int   n;
    served = 2'b00;
    seen   = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick;
      if (s_valid === 1'b1) seen = 1'b1;
    end
    checkOutput("s_valid_rise", s_valid, 1);
    if (!seen || exp_q.size() == 0) return;
    t      = exp_q.pop_front();
    served = t.grant;
    checkOutput("grant_busy", grant, t.grant);
    checkOutput("s_address", s_address, t.addr);
    checkOutput("s_wdata", s_wdata, t.wdata);
    checkOutput("s_nwr", s_nwr, t.nwr);
    if (t.grant[0]) begin
      m0_address = 16'hDEAD; m0_wdata = 16'hDEAD; m0_nwr = ~t.nwr;
    end else begin
      m1_address = 16'hDEAD; m1_wdata = 16'hDEAD; m1_nwr = ~t.nwr;
    end
    n = respond ? latency : LIMIT - 1;
    for (int i = 0; i < n; i++) begin
      tick;
      checkOutput("s_valid_hold", s_valid, 1);
      checkOutput("s_address_hold", s_address, t.addr);
      checkOutput("s_wdata_hold", s_wdata, t.wdata);
      checkOutput("s_nwr_hold", s_nwr, t.nwr);
      checkOutput("m0_ready_busy", m0_ready, 0);
      checkOutput("m1_ready_busy", m1_ready, 0);
    end
    if (respond) begin
      s_ready = 1'b1; s_rdata = t.slave_data;
    end else begin
      s_rdata = 16'h5A5A;
    end
    tick;
    s_ready = 1'b0;
    checkOutput("grant_resp", grant, t.grant);
    checkOutput("m0_ready_resp", m0_ready, t.grant[0]);
    checkOutput("m1_ready_resp", m1_ready, t.grant[1]);
    checkOutput("m0_error_resp", m0_error, t.grant[0] & t.err);
    checkOutput("m1_error_resp", m1_error, t.grant[1] & t.err);
    checkOutput("s_valid_resp", s_valid, 0);
    checkOutput("s_nwr_resp", s_nwr, 1);
    if (t.grant[0]) begin
      checkOutput("m0_rdata_resp", m0_rdata, t.rdata);
      checkOutput("m1_rdata_kept", m1_rdata, last_rdata[1]);
      last_rdata[0] = t.rdata;
      m0_valid = 1'b0;
    end else begin
      checkOutput("m1_rdata_resp", m1_rdata, t.rdata);
      checkOutput("m0_rdata_kept", m0_rdata, last_rdata[0]);
      last_rdata[1] = t.rdata;
      m1_valid = 1'b0;
    end
    tick;
    checkOutput("grant_idle", grant, 0);
    checkOutput("m0_ready_idle", m0_ready, 0);
    checkOutput("m1_ready_idle", m1_ready, 0);
    checkOutput("m0_error_idle", m0_error, 0);
    checkOutput("m1_error_idle", m1_error, 0);
    checkOutput("s_valid_idle", s_valid, 0);
  endtask

  task automatic checkResetValues(input string where);
    checkOutput({where, "_s_valid"}, s_valid, 0);
    checkOutput({where, "_s_nwr"}, s_nwr, 1);
    checkOutput({where, "_s_address"}, s_address, 0);
    checkOutput({where, "_s_wdata"}, s_wdata, 0);
    checkOutput({where, "_grant"}, grant, 0);
    checkOutput({where, "_m0_ready"}, m0_ready, 0);
    checkOutput({where, "_m0_error"}, m0_error, 0);
    checkOutput({where, "_m0_rdata"}, m0_rdata, 0);
    checkOutput({where, "_m1_ready"}, m1_ready, 0);
    checkOutput({where, "_m1_error"}, m1_error, 0);
    checkOutput({where, "_m1_rdata"}, m1_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [1:0] served;
    int         k0, k1;
    nreset   = 1'b0;
    m0_valid = 1'b0; m0_nwr = 1'b1; m0_address = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_nwr = 1'b1; m1_address = '0; m1_wdata = '0;
    s_ready  = 1'b0; s_rdata = '0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    tick;
    tick;
    checkResetValues("reset");
    nreset = 1'b1;
    tick;

    $display("[TB] s_ready pulse while idle");
    s_ready = 1'b1; s_rdata = 16'h7777;
    tick;
    s_ready = 1'b0;
    checkOutput("idle_pulse_grant", grant, 0);
    checkOutput("idle_pulse_s_valid", s_valid, 0);
    checkOutput("idle_pulse_m0_ready", m0_ready, 0);
    checkOutput("idle_pulse_m1_ready", m1_ready, 0);
    tick;
    checkOutput("idle_pulse_m0_rdata", m0_rdata, 0);
    checkOutput("idle_pulse_m1_ready2", m1_ready, 0);

    $display("[TB] simultaneous writes from reset, m0 first");
    applyStimulus(0, 1'b0, 16'h0020, 16'h1234, 16'h0A0A, 1'b0);
    applyStimulus(1, 1'b0, 16'h0030, 16'h5678, 16'h0B0B, 1'b0);
    serveSlave(1, 1'b1, served);
    serveSlave(0, 1'b1, served);

    $display("[TB] continuous requests alternate");
    applyStimulus(0, 1'b1, 16'h0100, 16'h0000, 16'hA000, 1'b0);
    applyStimulus(1, 1'b1, 16'h0200, 16'h0000, 16'hB000, 1'b0);
    k0 = 1;
    k1 = 1;
    for (int i = 0; i < 8; i++) begin
      serveSlave(i % 3, 1'b1, served);
      checkOutput("rr_alternate", served, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (served == 2'b01 && k0 < 4) begin
        applyStimulus(0, 1'b1, 16'h0100 + 16'(k0), 16'h0000, 16'hA000 + 16'(k0), 1'b0);
        k0++;
      end else if (served == 2'b10 && k1 < 4) begin
        applyStimulus(1, 1'b1, 16'h0200 + 16'(k1), 16'h0000, 16'hB000 + 16'(k1), 1'b0);
        k1++;
      end
    end

    $display("[TB] m0 read with two-cycle slave latency");
    applyStimulus(0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    serveSlave(2, 1'b1, served);

    $display("[TB] m1 read with hung slave");
    applyStimulus(1, 1'b1, 16'h0040, 16'h0000, 16'h0000, 1'b1);
    serveSlave(0, 1'b0, served);

    $display("[TB] s_ready on the watchdog's last cycle");
    applyStimulus(1, 1'b1, 16'h0050, 16'h0000, 16'h3C3C, 1'b0);
    serveSlave(LIMIT - 1, 1'b1, served);

    $display("[TB] reset during busy");
    m0_valid = 1'b1; m0_nwr = 1'b0; m0_address = 16'h0060; m0_wdata = 16'hCAFE;
    tick;
    checkOutput("pre_reset_s_valid", s_valid, 1);
    checkOutput("pre_reset_grant", grant, 2'b01);
    nreset = 1'b0;
    tick;
    checkResetValues("mid_busy_reset");
    m0_valid = 1'b0;
    nreset   = 1'b1;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("post_reset_m0_ready", m0_ready, 0);
      checkOutput("post_reset_s_valid", s_valid, 0);
    end

    $display("[TB] tie after reset goes to m0 again");
    applyStimulus(0, 1'b0, 16'h0070, 16'h1111, 16'h2222, 1'b0);
    applyStimulus(1, 1'b1, 16'h0080, 16'h0000, 16'h4444, 1'b0);
    serveSlave(1, 1'b1, served);
    serveSlave(3, 1'b1, served);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
